// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// The TRAP state exists only when MCTRL_ILLEGAL_TRAP_EN is defined.
package mctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_ALU_WB, S_EXEC_B, S_JAL,
        S_EXEC_JALR, S_JALR_PC, S_FAULT
`ifdef MCTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I} alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] A_PC = 2'd0, A_OLD_PC = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_CONST4 = 2'd2;
    localparam logic [1:0] RES_ALU_OUT = 2'd0, RES_MEM_DATA = 2'd1, RES_ALU = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic [2:0] imm_sel_of(input logic [6:0] op);
        case (op)
            OP_SW:           return IMM_S;
            OP_B:            return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:          return IMM_J;
            default:         return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mctrl_alu_decode.sv
// Maps the controller's ALU operation class plus funct3/funct7 to an ALU code.
module mctrl_alu_decode
    import mctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  alu_op_t               i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic [6:0]            i_funct7,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    logic [3:0] w_code;
    logic       w_unused_f7;

    assign w_unused_f7 = ^{i_funct7[6], i_funct7[4:0]};

    // funct7[5] selects SUB only for R-type, SRA for both R- and I-type shifts
    always_comb begin
        w_code = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: w_code = ALU_ADD;
            ALUOP_SUB: w_code = ALU_SUB;
            default: begin
                case (i_funct3)
                    3'b000:  w_code = (i_alu_op == ALUOP_R && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_code = ALU_SLL;
                    3'b010:  w_code = ALU_SLT;
                    3'b011:  w_code = ALU_SLTU;
                    3'b100:  w_code = ALU_XOR;
                    3'b101:  w_code = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_code = ALU_OR;
                    default: w_code = ALU_AND;
                endcase
            end
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM with memory-wait timeout.
// Optional: define MCTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes
// instead of treating them as a NOP.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ready,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic                  instr_flop_wen,
    output logic                  pc_wen,
    output logic                  addr_src,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            imm_sel,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_a_src,
    output logic [1:0]            alu_b_src,
    output logic                  fault,
    output logic                  trap
);

    state_t r_state;
    logic [7:0] r_cnt;

    logic w_wait, w_tmo, w_take;
    logic w_ifw, w_pcw, w_addr, w_mreq, w_mwr, w_rwr;
    logic [1:0] w_res, w_a, w_b;
    alu_op_t w_alu_op;
    logic [ALU_CTRL_W-1:0] w_alu_ctrl;

    assign w_wait = (r_state == S_FETCH || r_state == S_MEM_READ || r_state == S_MEM_WRITE) && !mem_ready;
    assign w_tmo  = w_wait && (r_cnt == 8'(MEM_TIMEOUT - 1));

    // Branch condition decode from funct3 and ALU flags
    always_comb begin
        case (funct3)
            3'b000:  w_take = alu_zero;
            3'b001:  w_take = !alu_zero;
            3'b100:  w_take = alu_lt;
            3'b101:  w_take = !alu_lt;
            3'b110:  w_take = alu_ltu;
            3'b111:  w_take = !alu_ltu;
            default: w_take = 1'b0;
        endcase
    end

    // State register and wait-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_wait ? r_cnt + 8'd1 : '0;
            if (w_tmo) begin
                r_state <= S_FAULT;
            end else begin
                case (r_state)
                    S_FETCH:     if (mem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                            OP_R:         r_state <= S_EXEC_R;
                            OP_I:         r_state <= S_EXEC_I;
                            OP_LUI:       r_state <= S_EXEC_LUI;
                            OP_AUIPC:     r_state <= S_ALU_WB;
                            OP_B:         r_state <= S_EXEC_B;
                            OP_JAL:       r_state <= S_JAL;
                            OP_JALR:      r_state <= S_EXEC_JALR;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                            default:      r_state <= S_TRAP;
`else
                            default:      r_state <= S_FETCH;
`endif
                        endcase
                    end
                    S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                    S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
                    S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
                    S_EXEC_R, S_EXEC_I, S_EXEC_LUI: r_state <= S_ALU_WB;
                    S_JAL:       r_state <= S_ALU_WB;
                    S_EXEC_JALR: r_state <= S_JALR_PC;
                    S_JALR_PC:   r_state <= S_ALU_WB;
                    S_FAULT:     r_state <= S_FAULT;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    S_TRAP:      r_state <= S_TRAP;
`endif
                    default:     r_state <= S_FETCH;
                endcase
            end
        end
    end

    // Per-state datapath strobes; FETCH and EXEC_B depend on same-cycle inputs
    always_comb begin
        w_ifw = 1'b0; w_pcw = 1'b0; w_addr = 1'b0; w_mreq = 1'b0; w_mwr = 1'b0; w_rwr = 1'b0;
        w_res = RES_ALU_OUT; w_a = A_PC; w_b = B_RS2; w_alu_op = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_mreq = 1'b1; w_a = A_PC; w_b = B_CONST4; w_res = RES_ALU;
                w_ifw = mem_ready; w_pcw = mem_ready;
            end
            S_DECODE:    begin w_a = A_OLD_PC; w_b = B_IMM; end
            S_MEM_ADDR:  begin w_a = A_RS1; w_b = B_IMM; end
            S_MEM_READ:  begin w_addr = 1'b1; w_mreq = 1'b1; end
            S_MEM_WRITE: begin w_addr = 1'b1; w_mreq = 1'b1; w_mwr = 1'b1; end
            S_MEM_WB:    begin w_res = RES_MEM_DATA; w_rwr = 1'b1; end
            S_ALU_WB:    begin w_res = RES_ALU_OUT; w_rwr = 1'b1; end
            S_EXEC_R:    begin w_a = A_RS1; w_b = B_RS2; w_alu_op = ALUOP_R; end
            S_EXEC_I:    begin w_a = A_RS1; w_b = B_IMM; w_alu_op = ALUOP_I; end
            S_EXEC_LUI:  begin w_a = A_ZERO; w_b = B_IMM; end
            S_EXEC_B: begin
                w_a = A_RS1; w_b = B_RS2; w_alu_op = ALUOP_SUB; w_pcw = w_take;
            end
            S_JAL, S_JALR_PC: begin
                w_a = A_OLD_PC; w_b = B_CONST4; w_res = RES_ALU_OUT; w_pcw = 1'b1;
            end
            S_EXEC_JALR: begin w_a = A_RS1; w_b = B_IMM; end
            default: ;
        endcase
    end

    mctrl_alu_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decode (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .o_alu_control (w_alu_ctrl)
    );

    // Reset forces every output low, abandoning any in-flight memory request
    assign instr_flop_wen = rst & w_ifw;
    assign pc_wen         = rst & w_pcw;
    assign addr_src       = rst & w_addr;
    assign mem_req        = rst & w_mreq;
    assign mem_write      = rst & w_mwr;
    assign reg_write      = rst & w_rwr;
    assign alu_control    = rst ? w_alu_ctrl : '0;
    assign imm_sel        = rst ? imm_sel_of(opcode) : '0;
    assign result_src     = rst ? w_res : '0;
    assign alu_a_src      = rst ? w_a : '0;
    assign alu_b_src      = rst ? w_b : '0;
    assign fault          = rst && (r_state == S_FAULT);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign trap           = rst && (r_state == S_TRAP);
`else
    assign trap           = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (MEM_TIMEOUT=4).
// Illegal-opcode expectations follow MCTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_ready = 1'b0;
    logic alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;

    logic instr_flop_wen, pc_wen, addr_src, mem_req, mem_write, reg_write;
    logic [3:0] alu_control;
    logic [2:0] imm_sel;
    logic [1:0] result_src, alu_a_src, alu_b_src;
    logic fault, trap;

    int n_pass = 0;
    int n_total = 0;

    logic [20:0] w_obs;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .instr_flop_wen(instr_flop_wen), .pc_wen(pc_wen), .addr_src(addr_src),
        .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write),
        .alu_control(alu_control), .imm_sel(imm_sel), .result_src(result_src),
        .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .fault(fault), .trap(trap)
    );

    always #5 clk = ~clk;

    assign w_obs = {instr_flop_wen, pc_wen, addr_src, mem_req, mem_write, reg_write,
                    alu_control, imm_sel, result_src, alu_a_src, alu_b_src, fault, trap};

    // Expected output vector: ifw pcw addr mreq mwr rwr | alu imm res a b | fault trap
    function automatic logic [20:0] ev(input logic ifw, pcw, as, mr, mw, rw,
                                       input logic [3:0] ac, input logic [2:0] is,
                                       input logic [1:0] rs, a, b, input logic f, t);
        return {ifw, pcw, as, mr, mw, rw, ac, is, rs, a, b, f, t};
    endfunction

    function automatic logic [20:0] fetch_v(input logic rdy, input logic [2:0] is);
        return ev(rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, is, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] dec_v(input logic [2:0] is);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, is, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] wb_v(input logic [2:0] is, input logic [1:0] rs);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, is, rs, 2'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [20:0] exp);
        n_total++;
        assert (w_obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
    endtask

    // Check the current cycle, then advance to just after the next rising edge
    task automatic step(input string tag, input logic [20:0] exp);
        #1;
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("reset_outputs_zero", '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset with mem_ready high: no request may escape while rst is low
        mem_ready = 1'b1;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        #2;
        check("reset_idle", '0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ADD x3,x1,x2: 4 cycles, reg_write only in the last
        step("add_fetch",  fetch_v(1'b1, 3'd0));
        step("add_decode", dec_v(3'd0));
        step("add_exec_r", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd2, 2'd0, 0, 0));
        step("add_alu_wb", wb_v(3'd0, 2'd0));

        // SUB via R-type funct7[5]
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        step("sub_fetch",  fetch_v(1'b1, 3'd0));
        step("sub_decode", dec_v(3'd0));
        step("sub_exec_r", ev(0, 0, 0, 0, 0, 0, 4'd1, 3'd0, 2'd0, 2'd2, 2'd0, 0, 0));
        step("sub_alu_wb", wb_v(3'd0, 2'd0));

        // ADDI with funct7[5] set in the immediate: still ADD
        set_instr(7'b0010011, 3'b000, 7'b0100000);
        step("addi_fetch",  fetch_v(1'b1, 3'd0));
        step("addi_decode", dec_v(3'd0));
        step("addi_exec_i", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd2, 2'd1, 0, 0));
        step("addi_alu_wb", wb_v(3'd0, 2'd0));

        // SRAI: shift keeps funct7[5]
        set_instr(7'b0010011, 3'b101, 7'b0100000);
        step("srai_fetch",  fetch_v(1'b1, 3'd0));
        step("srai_decode", dec_v(3'd0));
        step("srai_exec_i", ev(0, 0, 0, 0, 0, 0, 4'd7, 3'd0, 2'd0, 2'd2, 2'd1, 0, 0));
        step("srai_alu_wb", wb_v(3'd0, 2'd0));

        // BNE not equal: taken
        set_instr(7'b1100011, 3'b001, 7'b0000000);
        alu_zero = 1'b0;
        step("bne_t_fetch",  fetch_v(1'b1, 3'd2));
        step("bne_t_decode", dec_v(3'd2));
        step("bne_t_exec",   ev(0, 1, 0, 0, 0, 0, 4'd1, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0));

        // BNE equal: not taken
        alu_zero = 1'b1;
        step("bne_n_fetch",  fetch_v(1'b1, 3'd2));
        step("bne_n_decode", dec_v(3'd2));
        step("bne_n_exec",   ev(0, 0, 0, 0, 0, 0, 4'd1, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0));

        // funct3=010 never branches, whatever the flags
        set_instr(7'b1100011, 3'b010, 7'b0000000);
        alu_zero = 1'b1; alu_lt = 1'b1; alu_ltu = 1'b1;
        step("b010_fetch",  fetch_v(1'b1, 3'd2));
        step("b010_decode", dec_v(3'd2));
        step("b010_exec",   ev(0, 0, 0, 0, 0, 0, 4'd1, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0));

        // BGEU with ltu=0: taken
        set_instr(7'b1100011, 3'b111, 7'b0000000);
        alu_zero = 1'b0; alu_lt = 1'b1; alu_ltu = 1'b0;
        step("bgeu_fetch",  fetch_v(1'b1, 3'd2));
        step("bgeu_decode", dec_v(3'd2));
        step("bgeu_exec",   ev(0, 1, 0, 0, 0, 0, 4'd1, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0));
        alu_lt = 1'b0;

        // LW with 3 wait cycles in MEM_READ (one short of the timeout): 8 cycles
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        step("lw_fetch",    fetch_v(1'b1, 3'd0));
        step("lw_decode",   dec_v(3'd0));
        step("lw_mem_addr", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd2, 2'd1, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw_mem_read_wait", ev(0, 0, 1, 1, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        mem_ready = 1'b1;
        step("lw_mem_read_rdy", ev(0, 0, 1, 1, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0));
        step("lw_mem_wb",       wb_v(3'd0, 2'd1));

        // SW: 4 cycles
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        step("sw_fetch",     fetch_v(1'b1, 3'd1));
        step("sw_decode",    dec_v(3'd1));
        step("sw_mem_addr",  ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd1, 2'd0, 2'd2, 2'd1, 0, 0));
        step("sw_mem_write", ev(0, 0, 1, 1, 1, 0, 4'd0, 3'd1, 2'd0, 2'd0, 2'd0, 0, 0));

        // AUIPC: 3 cycles
        set_instr(7'b0010111, 3'b000, 7'b0000000);
        step("auipc_fetch",  fetch_v(1'b1, 3'd3));
        step("auipc_decode", dec_v(3'd3));
        step("auipc_alu_wb", wb_v(3'd3, 2'd0));

        // LUI: 4 cycles
        set_instr(7'b0110111, 3'b000, 7'b0000000);
        step("lui_fetch",  fetch_v(1'b1, 3'd3));
        step("lui_decode", dec_v(3'd3));
        step("lui_exec",   ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd3, 2'd0, 2'd3, 2'd1, 0, 0));
        step("lui_alu_wb", wb_v(3'd3, 2'd0));

        // JAL: 4 cycles
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        step("jal_fetch",  fetch_v(1'b1, 3'd4));
        step("jal_decode", dec_v(3'd4));
        step("jal_jal",    ev(0, 1, 0, 0, 0, 0, 4'd0, 3'd4, 2'd0, 2'd1, 2'd2, 0, 0));
        step("jal_alu_wb", wb_v(3'd4, 2'd0));

        // JALR: 5 cycles
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        step("jalr_fetch",   fetch_v(1'b1, 3'd0));
        step("jalr_decode",  dec_v(3'd0));
        step("jalr_exec",    ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd2, 2'd1, 0, 0));
        step("jalr_pc",      ev(0, 1, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd1, 2'd2, 0, 0));
        step("jalr_alu_wb",  wb_v(3'd0, 2'd0));
        step("after_jalr_fetch", fetch_v(1'b1, 3'd0));

        // JALR again, reset asserted in the middle of JALR_PC
        step("jalr2_decode", dec_v(3'd0));
        step("jalr2_exec",   ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd2, 2'd1, 0, 0));
        #1;
        check("jalr2_pc", ev(0, 1, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd1, 2'd2, 0, 0));
        #1;
        rst = 1'b0;
        #1;
        check("jalr2_async_reset", '0);
        @(posedge clk);
        #1;
        check("jalr2_reset_held", '0);
        rst = 1'b1;
        step("post_reset_fetch", fetch_v(1'b1, 3'd0));

        // Illegal opcode
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        step("ill_decode", dec_v(3'd0));
`ifdef MCTRL_ILLEGAL_TRAP_EN
        step("ill_trap",      ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 1));
        step("ill_trap_held", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 1));
`else
        step("ill_nop_fetch", fetch_v(1'b1, 3'd0));
        step("ill_nop_decode", dec_v(3'd0));
        step("ill_nop_fetch2", fetch_v(1'b1, 3'd0));
`endif
        do_reset();

        // Timeout in FETCH: 4 wait cycles then sticky fault
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            step("tmo_fetch_wait", fetch_v(1'b0, 3'd0));
        step("tmo_fault", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1, 0));
        mem_ready = 1'b1;
        step("tmo_fault_held", ev(0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1, 0));
        do_reset();
        step("tmo_cleared_fetch", fetch_v(1'b1, 3'd0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: wait-state cycles without mem_ready before fault; legal range 1..255.
REQ-002 Parameter ALU_CTRL_W, default 4: width of the alu_control output.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port list (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_ready  in  1  memory completes the current request.
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- opcode  in  7; funct3  in  3; funct7  in  7  fields of the latched instruction.
- instr_flop_wen, pc_wen, addr_src, mem_req, mem_write, reg_write  out  1 each  datapath strobes.
- alu_control  out  ALU_CTRL_W  ALU operation.
- imm_sel  out  3  immediate format.
- result_src, alu_a_src, alu_b_src  out  2 each  datapath mux selects.
- fault  out  1  sticky memory-timeout flag.
- trap  out  1  sticky illegal-opcode flag.

Function
REQ-005 Mux encodings:
- alu_a_src: 0=PC, 1=OLD_PC, 2=RS1, 3=ZERO.
- alu_b_src: 0=RS2, 1=IMM, 2=CONST4.
- result_src: 0=ALU_OUT register, 1=MEM_DATA, 2=ALU result.
REQ-006 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_LUI, ALU_WB, EXEC_B, JAL, EXEC_JALR, JALR_PC, FAULT, TRAP.
REQ-007 Default value of every output in every state is 0 unless a REQ below asserts it.
REQ-008 FETCH: mem_req=1, a=PC, b=CONST4, result_src=2.
- Holds until mem_ready.
- In the mem_ready cycle, assert instr_flop_wen=1 and pc_wen=1, then go to DECODE.
REQ-009 DECODE: a=OLD_PC, b=IMM, so branch/JAL/AUIPC target lands in ALU_OUT. Dispatch by opcode:
- LW -> MEM_ADDR; SW -> MEM_ADDR.
- R -> EXEC_R; I -> EXEC_I; LUI -> EXEC_LUI; AUIPC -> ALU_WB.
- B -> EXEC_B; JAL -> JAL; JALR -> EXEC_JALR.
- Anything else -> illegal (REQ-020).
REQ-010 MEM_ADDR: a=RS1, b=IMM. Next state MEM_WRITE for SW, else MEM_READ.
REQ-011 MEM_READ: addr_src=1, mem_req=1; holds until mem_ready, then MEM_WB.
REQ-012 MEM_WRITE: addr_src=1, mem_req=1, mem_write=1; holds until mem_ready, then FETCH.
REQ-013 Write-back states, each followed by FETCH:
- MEM_WB: result_src=1, reg_write=1.
- ALU_WB: result_src=0, reg_write=1.
REQ-014 ALU operand states, each followed by ALU_WB:
- EXEC_R: a=RS1, b=RS2.
- EXEC_I: a=RS1, b=IMM.
- EXEC_LUI: a=ZERO, b=IMM, alu_control=ADD.
REQ-015 EXEC_B: a=RS1, b=RS2, ALU SUB, result_src=0; next state FETCH.
- pc_wen = take, decoded from funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- funct3 010/011: take=0.
REQ-016 Jumps:
- JAL: a=OLD_PC, b=CONST4, result_src=0, pc_wen=1; then ALU_WB.
- EXEC_JALR: a=RS1, b=IMM; then JALR_PC.
- JALR_PC: same outputs as JAL; then ALU_WB.
REQ-017 alu_control: ADD in FETCH, DECODE, MEM_ADDR, JAL, JALR_PC and EXEC_JALR; SUB in EXEC_B; funct3/funct7 decode in EXEC_R/EXEC_I (funct7[5] ignored for I-type except shifts).
REQ-018 imm_sel is decoded combinationally from opcode in all states.
REQ-019 Zero-wait latency in cycles: R/I/LUI 4, AUIPC 3, LW 5, SW 4, B 3, JAL 4, JALR 5.
REQ-020 Illegal opcode handling is set by MCTRL_ILLEGAL_TRAP_EN (REQ-025).
REQ-021 Timeout counter:
- Increments each FETCH/MEM_READ/MEM_WRITE cycle with mem_ready=0.
- Clears on mem_ready and on any other state.
- Reaching MEM_TIMEOUT enters FAULT: all strobes 0, fault=1, held until reset.
- mem_ready in the same cycle the count reaches MEM_TIMEOUT takes priority and completes normally.

Reset
REQ-022 rst low: state=FETCH, counter=0, fault=0, trap=0, asynchronously.
REQ-023 While rst is low, all outputs are 0, including mem_req; reset mid-wait abandons the request.
REQ-024 First FETCH request is issued in the first cycle after rst rises.

Configuration
REQ-025 Macro MCTRL_ILLEGAL_TRAP_EN:
- Defined: illegal opcode in DECODE enters TRAP with all strobes 0 and trap=1, held until reset.
- Undefined: illegal opcode returns to FETCH (NOP), TRAP state absent, trap tied 0.

Structure
REQ-026 Package mctrl_pkg holds the state enum, opcode localparams, mux select encodings and alu_control codes.
REQ-027 One sub-module, mctrl_alu_decode, maps alu_op/funct3/funct7 to alu_control.

Verification
REQ-028 ADD x3,x1,x2 with mem_ready tied 1 -> 4 cycles, reg_write high only in cycle 4, result_src=0.
REQ-029 BNE with alu_zero=0 -> pc_wen=1 in EXEC_B; with alu_zero=1 -> pc_wen=0; both return to FETCH after 3 cycles.
REQ-030 LW with mem_ready low 3 cycles in MEM_READ -> MEM_WB in the cycle after ready; total 8 cycles.
REQ-031 MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> fault=1 after 4 wait cycles and stays set; rst low clears it.
REQ-032 Opcode 7'b1111111 -> trap=1 with macro defined; with macro undefined, back in FETCH the cycle after DECODE.
REQ-033 JALR -> EXEC_JALR, JALR_PC (pc_wen=1), ALU_WB (reg_write=1), then FETCH; rst low mid-JALR_PC -> all outputs 0 immediately.
